// File: rtl/microsequencer_pkg.sv
// Shared constants for the microsequencer: raw microinstruction words,
// II/AI/XI field masks (also used by the Control bench) and widths.
package microsequencer_pkg;

    localparam int STEP_BITS   = 3;
    localparam int OPCODE_BITS = 8;
    localparam int FETCH_STEPS = 2;
    localparam int ADDR_BITS   = OPCODE_BITS + STEP_BITS;

    // Raw encoding as stored in ROM: bit 15 (EO) is active-low.
    localparam logic [15:0] FETCH0 = 16'h8020;
    localparam logic [15:0] FETCH1 = 16'hB440;
    localparam logic [15:0] UEND   = 16'h8000;
    localparam logic [15:0] UIDLE  = 16'h0000;

    // Destination field lives in bits 7:5; MI (AI|II) must not match II.
    localparam logic [15:0] DEST_MASK = 16'h00E0;
    localparam logic [15:0] II_MATCH  = 16'h0040;
    localparam logic [15:0] AI_MATCH  = 16'h0020;
    localparam logic [15:0] XI_MATCH  = 16'h0060;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_t;

    function automatic logic is_ii(input logic [15:0] word);
        return (word & DEST_MASK) == II_MATCH;
    endfunction

endpackage

// File: rtl/microsequencer_if.sv
// Bus-side signals of the microsequencer: ROM address/data, main bus,
// halt request and the microinstruction stream toward Control.
interface microsequencer_if;
    import microsequencer_pkg::*;

    logic [15:0]          bus_in;
    logic [15:0]          rom_data;
    logic                 halt_req;
    logic [ADDR_BITS-1:0] rom_addr;
    logic [15:0]          uinstr;
    logic [STEP_BITS-1:0] step;
    logic                 halted;

    modport master (
        input  bus_in, rom_data, halt_req,
        output rom_addr, uinstr, step, halted
    );

    modport slave (
        output bus_in, rom_data, halt_req,
        input  rom_addr, uinstr, step, halted
    );

endinterface

// File: rtl/microsequencer_step_counter.sv
// T-state counter: synchronous clear, increment or hold.
module microsequencer_step_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_bar,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_bar || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/microsequencer.sv
// Microsequencer: fetch steps, opcode latch, early termination and
// halt at instruction boundaries.
//   state   | meaning
//   ST_RUN  | stepping through fetch and ROM microinstructions
//   ST_HALT | parked at step 0 emitting UIDLE until halt_req drops
module microsequencer
    import microsequencer_pkg::*;
(
    input  logic clk,
    input  logic rst_bar,
    microsequencer_if.master bus
);

    seq_state_t             state;
    logic [OPCODE_BITS-1:0] opcode;
    logic [STEP_BITS-1:0]   step_q;
    logic [15:0]            uinstr_c;
    logic                   term;
    logic                   wrap;
    logic                   end_instr;
    logic                   halted;
    logic                   step_clr;
    logic                   step_inc;
    logic                   unused_bus_lo;

    assign halted = (state == ST_HALT);

    always_comb begin
        uinstr_c = bus.rom_data;
        if (halted) begin
            uinstr_c = UIDLE;
        end else if (step_q == STEP_BITS'(0)) begin
            uinstr_c = FETCH0;
        end else if (step_q == STEP_BITS'(1)) begin
            uinstr_c = FETCH1;
        end
    end

    // Halted always sits at step 0, so the terminator cannot fire there.
    assign term      = (step_q >= STEP_BITS'(FETCH_STEPS)) && (bus.rom_data == UEND);
    assign wrap      = (step_q == '1);
    assign end_instr = term || wrap;
    assign step_clr  = !halted && end_instr;
    assign step_inc  = !halted && !end_instr;

    microsequencer_step_counter #(
        .WIDTH (STEP_BITS)
    ) u_step (
        .clk     (clk),
        .rst_bar (rst_bar),
        .clr     (step_clr),
        .inc     (step_inc),
        .count   (step_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_bar) begin
            state  <= ST_RUN;
            opcode <= '0;
        end else begin
            if (is_ii(uinstr_c)) begin
                opcode <= bus.bus_in[15 -: OPCODE_BITS];
            end
            case (state)
                ST_RUN:  if (end_instr && bus.halt_req) state <= ST_HALT;
                ST_HALT: if (!bus.halt_req) state <= ST_RUN;
                default: state <= ST_RUN;
            endcase
        end
    end

    assign unused_bus_lo = ^bus.bus_in[15-OPCODE_BITS:0];

    assign bus.rom_addr = {opcode, step_q};
    assign bus.uinstr   = uinstr_c;
    assign bus.step     = step_q;
    assign bus.halted   = halted;

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for the microsequencer: fetch, latch, termination,
// wrap, halt/resume and reset abort.
module tb_microsequencer;
    import microsequencer_pkg::*;

    logic clk;
    logic rst_bar;
    int   n_cmp;
    int   n_bad;

    microsequencer_if ms_if ();

    microsequencer dut (
        .clk     (clk),
        .rst_bar (rst_bar),
        .bus     (ms_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_bar = 1'b0;
        ms_if.bus_in   = 16'h0000;
        ms_if.rom_data = 16'h1234;
        ms_if.halt_req = 1'b0;

        tick();
        tick();
        chk_eq("rst_uinstr", 32'(ms_if.uinstr), 32'h8020);
        chk_eq("rst_addr", 32'(ms_if.rom_addr), 32'h000);
        chk_eq("rst_step", 32'(ms_if.step), 32'd0);
        chk_eq("rst_halted", 32'(ms_if.halted), 32'd0);
        rst_bar = 1'b1;

        // End word during fetch steps must be ignored.
        ms_if.rom_data = 16'h8000;
        #1;
        chk_eq("s0_uinstr", 32'(ms_if.uinstr), 32'h8020);
        tick();
        chk_eq("s1_step", 32'(ms_if.step), 32'd1);
        chk_eq("s1_uinstr", 32'(ms_if.uinstr), 32'hB440);
        ms_if.bus_in = 16'h2A00;
        tick();
        chk_eq("s2_step", 32'(ms_if.step), 32'd2);
        chk_eq("s2_addr", 32'(ms_if.rom_addr), 32'h152);

        ms_if.rom_data = 16'h8060;
        ms_if.bus_in   = 16'hFF00;
        #1;
        chk_eq("s2_uinstr", 32'(ms_if.uinstr), 32'h8060);
        tick();
        chk_eq("mi_nolatch_addr", 32'(ms_if.rom_addr), 32'h153);

        ms_if.rom_data = 16'h8000;
        tick();
        chk_eq("term_step", 32'(ms_if.step), 32'd0);
        chk_eq("term_uinstr", 32'(ms_if.uinstr), 32'h8020);
        chk_eq("term_addr", 32'(ms_if.rom_addr), 32'h150);

        ms_if.rom_data = 16'h1234;
        ms_if.bus_in   = 16'h3C00;
        for (int k = 1; k < 8; k++) begin
            tick();
            chk_eq($sformatf("wrap_step%0d", k), 32'(ms_if.step), 32'(k));
            if (k == 5) chk_eq("wrap_addr5", 32'(ms_if.rom_addr), 32'h1E5);
        end
        tick();
        chk_eq("wrap_to0", 32'(ms_if.step), 32'd0);

        for (int k = 0; k < 4; k++) tick();
        chk_eq("pre_halt_step", 32'(ms_if.step), 32'd4);
        ms_if.halt_req = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk_eq("halt_s7_step", 32'(ms_if.step), 32'd7);
        chk_eq("halt_s7_halted", 32'(ms_if.halted), 32'd0);
        tick();
        chk_eq("halt_halted", 32'(ms_if.halted), 32'd1);
        chk_eq("halt_step", 32'(ms_if.step), 32'd0);
        chk_eq("halt_uinstr", 32'(ms_if.uinstr), 32'h0000);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_eq($sformatf("hold%0d_halted", k), 32'(ms_if.halted), 32'd1);
            chk_eq($sformatf("hold%0d_addr", k), 32'(ms_if.rom_addr), 32'h1E0);
        end

        ms_if.halt_req = 1'b0;
        tick();
        chk_eq("resume_halted", 32'(ms_if.halted), 32'd0);
        chk_eq("resume_step", 32'(ms_if.step), 32'd0);
        chk_eq("resume_uinstr", 32'(ms_if.uinstr), 32'h8020);
        tick();
        chk_eq("resume_s1", 32'(ms_if.step), 32'd1);
        tick();
        chk_eq("resume_s2", 32'(ms_if.step), 32'd2);

        // A halt pulse that ends inside the instruction must not halt.
        ms_if.halt_req = 1'b1;
        tick();
        ms_if.halt_req = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk_eq("pulse_s7", 32'(ms_if.step), 32'd7);
        tick();
        chk_eq("pulse_step", 32'(ms_if.step), 32'd0);
        chk_eq("pulse_halted", 32'(ms_if.halted), 32'd0);

        for (int k = 0; k < 5; k++) tick();
        chk_eq("abort_pre_step", 32'(ms_if.step), 32'd5);
        rst_bar = 1'b0;
        tick();
        chk_eq("abort_step", 32'(ms_if.step), 32'd0);
        chk_eq("abort_addr", 32'(ms_if.rom_addr), 32'h000);
        chk_eq("abort_uinstr", 32'(ms_if.uinstr), 32'h8020);
        rst_bar = 1'b1;
        tick();
        chk_eq("post_abort_s1", 32'(ms_if.step), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Drives the 16-bit microinstruction word into the Control decoder, in the raw encoding Control consumes (bit 15 stored inverted, i.e. EO active-low in ROM).
- Holds the opcode register and the T-state step counter, and forms the microcode ROM address from them.
- Generates the two fixed fetch steps internally, terminates instructions early, and stalls the machine on halt at an instruction boundary.
- Sits between the microcode ROM and Control.

Parameters:
- STEP_BITS, 3, width of step counter; max steps per instruction = 2**STEP_BITS.
- OPCODE_BITS, 8, opcode width, taken from bus_in[15:16-OPCODE_BITS].
- FETCH_STEPS, 2, number of leading steps supplied from internal constants rather than ROM.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_bar  input  1  synchronous active-low reset, sampled on rising edge of clk.
- bus_in  input  16  main bus value; opcode source while the current microinstruction loads II.
- rom_data  input  16  raw microcode ROM word at rom_addr; combinational ROM, same-cycle valid.
- halt_req  input  1  request to stop at the next instruction boundary; level-sensitive.
- rom_addr  output  OPCODE_BITS+STEP_BITS  {opcode, step}; combinational from registers.
- uinstr  output  16  raw microinstruction to Control.
- step  output  STEP_BITS  current T-state.
- halted  output  1  sequencer parked at step 0 emitting the idle word.

Behaviour:
- Reset (rst_bar low at an edge): step=0, opcode=0, halted=0. Reset mid-instruction aborts it, with no partial state kept. While rst_bar is held low, outputs reflect the reset state: uinstr=16'h8020, rom_addr=0.
- uinstr selection, combinational, in priority order:
  - halted=1 -> 16'h0000 (EO selected, no destination, no jumps).
  - step=0 -> 16'h8020 (PO|AI).
  - step=1 -> 16'hB440 (MO|II|PP).
  - otherwise -> rom_data.
- Opcode latch: decode II from the current uinstr (bit7=0, bit6=1, bit5=0; MI, which is AI|II, must NOT latch). On that edge, opcode <= bus_in[15:8].
- Terminator: when step >= FETCH_STEPS and rom_data == 16'h8000 (decoded all-zero word), that step executes for one cycle (harmless) and the next step is 0.
- Step advance at each edge, not in reset, in priority order:
  - halted=1 and halt_req=1 -> hold.
  - halted=1 and halt_req=0 -> halted<=0, step stays 0.
  - next-step would be 0 (terminator, or step == 2**STEP_BITS-1 wrap) and halt_req=1 -> step<=0, halted<=1.
  - terminator or wrap -> step<=0.
  - else -> step<=step+1.
- Halt timing:
  - halt_req is ignored except at a boundary; an instruction in progress always completes.
  - halt_req asserted and dropped inside one instruction has no effect.
  - Resume from halt costs exactly one idle cycle, then fetch step 0.
- Simultaneous II and terminator on the same step: the opcode latches and the step goes to 0.
- rom_data is ignored during fetch steps and while halted; rom_addr still tracks {opcode, step}.

Decomposition:
- Shared package holds:
  - Raw-encoding constants: FETCH0=16'h8020, FETCH1=16'hB440, UEND=16'h8000, UIDLE=16'h0000.
  - Field masks for II/AI/XI decode, reused by the Control testbench.
- Optional sub-module step_counter: load-zero / increment / hold, with parameterised width.
- Control is instantiated by the parent, not inside this block.

Test Plan:
- Reset: rst_bar low 2 cycles, then high -> step=0, uinstr=16'h8020, rom_addr=11'h000, halted=0.
- Fetch/latch: bus_in=16'h2A00 during step 1 -> after edge opcode=8'h2A; at step 2 rom_addr=11'h152, uinstr=rom_data.
- MI no-latch: rom_data=16'h8060 (PO|MI) at step 2 with bus_in=16'hFF00 -> opcode stays 8'h2A.
- Terminator: rom_data=16'h8000 at step 3 -> next cycle step=0, uinstr=16'h8020; steps 4..7 never visited.
- Wrap: rom_data never 16'h8000 -> step sequence 0..7, then 0.
- Halt and reset abort:
  - halt_req=1 raised at step 4 -> instruction finishes; at boundary halted=1, step=0, uinstr=16'h0000, held for N cycles.
  - Drop halt_req -> one cycle with halted=0, step 0; then steps 1, 2 follow.
  - rst_bar low at step 5 -> step=0 on next edge.
